mem_buff_ctrl: RTL

FIFO controller that sits directly upstream of the 8-entry address-mapped memory buffer (mem_buff) and owns its write/read port.
- Converts a producer valid/ready byte stream into buffer writes at a circular write pointer.
- Drains entries in arrival order from a circular read pointer into a consumer valid/ready stream.
- Tracks occupancy itself and serialises the buffer's single-operation-per-cycle port with fair arbitration.

---
 rtl/mem_buff_pkg.sv | 32 +++
 rtl/mem_buff_ptr.sv | 27 ++
 rtl/mem_buff_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_buff_pkg.sv
// Shared constants and helpers for the mem_buff FIFO controller.
// Pointer/count widths are derived from an 8-entry power-of-two buffer.
package mem_buff_pkg;

    localparam int DEPTH   = 8;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int PTR_W   = 3;
    localparam int COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        BUF_IDLE  = 2'd0,
        BUF_WRITE = 2'd1,
        BUF_READ  = 2'd2
    } buf_op_e;

    // Circular increment; the last entry wraps back to entry zero.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = p + PTR_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [AW-1:0] ptr_to_addr(input logic [PTR_W-1:0] p);
        return {{(AW - PTR_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/mem_buff_ptr.sv
// Wrapping buffer pointer with increment enable.
// Used for both the write and the read side of the FIFO controller.
module mem_buff_ptr
    import mem_buff_pkg::*;
(
    input  logic             clk,
    input  logic             rest,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register: advances by one entry per accepted operation.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_next(ptr_r);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/mem_buff_ctrl.sv
// FIFO controller owning the single read/write port of the 8-entry mem_buff.
// Alternates write/read on contention; the fetched head byte is passed straight through.
module mem_buff_ctrl
    import mem_buff_pkg::*;
(
    input  logic               clk,
    input  logic               rest,
    input  logic               wr_valid,
    input  logic [DW-1:0]      wr_data,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    input  logic               rd_ready,
    output logic [COUNT_W-1:0] count,
    output logic [DW-1:0]      buf_data_in,
    output logic [AW-1:0]      buf_address,
    output logic               buf_en_w,
    output logic               buf_en_r,
    input  logic [DW-1:0]      buf_data_out
);

    logic [PTR_W-1:0]   wptr_s;
    logic [PTR_W-1:0]   rptr_s;
    logic [COUNT_W-1:0] count_r;
    logic               prio_rd_r;
    logic               rd_valid_r;

    logic               not_full_s;
    logic               rd_want_s;
    logic               wr_ready_s;
    logic               wr_go_s;
    logic               rd_go_s;
    logic               conflict_s;
    buf_op_e            op_s;

    // Handshake decode and arbitration between producer and consumer side.
    always_comb begin
        not_full_s = (count_r < COUNT_W'(DEPTH));
        rd_want_s  = (count_r != {COUNT_W{1'b0}}) && (!rd_valid_r || rd_ready);
        wr_ready_s = rest && not_full_s && !(rd_want_s && prio_rd_r);
        wr_go_s    = wr_valid && wr_ready_s;
        rd_go_s    = rest && rd_want_s && !wr_go_s;
        conflict_s = rest && rd_want_s && wr_valid && not_full_s;
        if (wr_go_s) begin
            op_s = BUF_WRITE;
        end else if (rd_go_s) begin
            op_s = BUF_READ;
        end else begin
            op_s = BUF_IDLE;
        end
    end

    // Buffer port drive; idle cycles park the address on the write pointer.
    always_comb begin
        buf_en_w    = 1'b0;
        buf_en_r    = 1'b0;
        buf_address = ptr_to_addr(wptr_s);
        buf_data_in = wr_data;
        if (!rest) begin
            buf_address = {AW{1'b0}};
            buf_data_in = {DW{1'b0}};
        end else begin
            case (op_s)
                BUF_WRITE: begin
                    buf_en_w    = 1'b1;
                    buf_address = ptr_to_addr(wptr_s);
                end
                BUF_READ: begin
                    buf_en_r    = 1'b1;
                    buf_address = ptr_to_addr(rptr_s);
                end
                default: begin
                    buf_en_w = 1'b0;
                    buf_en_r = 1'b0;
                end
            endcase
        end
    end

    mem_buff_ptr u_wptr (
        .clk  (clk),
        .rest (rest),
        .inc  (wr_go_s),
        .ptr  (wptr_s)
    );

    mem_buff_ptr u_rptr (
        .clk  (clk),
        .rest (rest),
        .inc  (rd_go_s),
        .ptr  (rptr_s)
    );

    // Occupancy: excludes the byte already fetched onto rd_data.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            count_r <= {COUNT_W{1'b0}};
        end else begin
            case ({wr_go_s, rd_go_s})
                2'b10:   count_r <= count_r + COUNT_W'(1);
                2'b01:   count_r <= count_r - COUNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Fairness token: flips on every contended cycle, write wins first.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            prio_rd_r <= 1'b0;
        end else if (conflict_s) begin
            prio_rd_r <= ~prio_rd_r;
        end else begin
            prio_rd_r <= prio_rd_r;
        end
    end

    // Output valid: set by a fetch, cleared once consumed without a refill.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rd_valid_r <= 1'b0;
        end else if (rd_go_s) begin
            rd_valid_r <= 1'b1;
        end else if (rd_valid_r && rd_ready) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_valid_r;
        end
    end

    assign wr_ready = wr_ready_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = buf_data_out;
    assign count    = count_r;

endmodule
